// File: rtl/mont_mult_seq.sv
// mont_mult_seq: sequences one shared external multiplier through a Montgomery
// modular multiplication, res = a*b*R^-1 mod N with R = 2^W.
//   T = a*b ; M = (T mod R)*N' mod R ; U = (T + M*N)/R ; res = U - N if U >= N.
// Optional feature macro: MONT_PERF_CNT_EN (adds op_cnt / cyc_cnt outputs).
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start          request pulse, sampled only in IDLE
//   a, b, n        operands and odd modulus (latched on accepted start)
//   nprime         N' = -N^-1 mod R
//   busy, done     busy MUL1..RED (registered), done one-cycle pulse with res
//   res            result, held until the next accepted start
//   mul_a, mul_b   multiplier operands (registered, held for a whole pass)
//   mul_p          multiplier product, valid MUL_LAT cycles after inputs change
//   op_cnt         (MONT_PERF_CNT_EN) completed operations, wrapping
//   cyc_cnt        (MONT_PERF_CNT_EN) busy cycles, saturating
module mont_mult_seq #(
    parameter int unsigned W       = 128,
    parameter int unsigned MW      = 129,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    input  logic [W-1:0]      n,
    input  logic [W-1:0]      nprime,
    output logic              busy,
    output logic              done,
    output logic [W-1:0]      res,
    output logic [MW-1:0]     mul_a,
    output logic [MW-1:0]     mul_b,
    input  logic [2*MW-1:0]   mul_p
`ifdef MONT_PERF_CNT_EN
    ,
    output logic [31:0]       op_cnt,
    output logic [31:0]       cyc_cnt
`endif
);

    localparam int unsigned CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
    localparam int unsigned SW = 2 * W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_MUL1, S_MUL2, S_MUL3, S_RED, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    n_q, np_q;
    logic [2*W-1:0]  t_q;
    logic [W:0]      u_q;
    logic [W-1:0]    res_next_q;

    logic            cnt_zero;
    logic            in_busy;
    logic [SW-1:0]   s_sum;
    logic [W-1:0]    red_d;
    logic [W:0]      u_minus_n;

    // Next-state logic plus the arithmetic feeding the datapath registers.
    always_comb begin
        state_d   = state_q;
        cnt_zero  = (cnt_q == '0);
        in_busy   = (state_q == S_MUL1) || (state_q == S_MUL2) ||
                    (state_q == S_MUL3) || (state_q == S_RED);
        // Full-width sum; the low W bits cancel to zero by construction.
        s_sum     = {1'b0, t_q} + {1'b0, mul_p[2*W-1:0]};
        u_minus_n = u_q - {1'b0, n_q};
        red_d     = (u_q >= {1'b0, n_q}) ? u_minus_n[W-1:0] : u_q[W-1:0];
        case (state_q)
            S_IDLE:  if (start)    state_d = S_MUL1;
            S_MUL1:  if (cnt_zero) state_d = S_MUL2;
            S_MUL2:  if (cnt_zero) state_d = S_MUL3;
            S_MUL3:  if (cnt_zero) state_d = S_RED;
            S_RED:                 state_d = S_DONE;
            S_DONE:                state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Datapath and registered outputs; outputs follow the current state by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            n_q        <= '0;
            np_q       <= '0;
            t_q        <= '0;
            u_q        <= '0;
            res_next_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            res        <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
        end else begin
            busy <= in_busy;
            done <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q   <= n;
                        np_q  <= nprime;
                        mul_a <= MW'(a);
                        mul_b <= MW'(b);
                        cnt_q <= CW'(MUL_LAT);
                    end
                end
                S_MUL1: begin
                    if (cnt_zero) begin
                        t_q   <= mul_p[2*W-1:0];
                        mul_a <= MW'(mul_p[W-1:0]);
                        mul_b <= MW'(np_q);
                        cnt_q <= CW'(MUL_LAT);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_MUL2: begin
                    // Only the low W bits of T*N' are M.
                    if (cnt_zero) begin
                        mul_a <= MW'(mul_p[W-1:0]);
                        mul_b <= MW'(n_q);
                        cnt_q <= CW'(MUL_LAT);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_MUL3: begin
                    if (cnt_zero) begin
                        u_q   <= s_sum[SW-1:W];
                        mul_a <= '0;
                        mul_b <= '0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_RED:   res_next_q <= red_d;
                S_DONE:  res        <= res_next_q;
                default: ;
            endcase
        end
    end

    // Product bits that the algorithm never needs.
    logic unused_bits;
    generate
        if (MW > W) begin : g_wide
            assign unused_bits = ^{s_sum[W-1:0], mul_p[2*MW-1:2*W]};
        end else begin : g_exact
            assign unused_bits = ^s_sum[W-1:0];
        end
    endgenerate

`ifdef MONT_PERF_CNT_EN
    // Operation counter wraps; busy-cycle counter saturates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_cnt  <= '0;
            cyc_cnt <= '0;
        end else begin
            if (state_q == S_DONE)          op_cnt  <= op_cnt + 32'd1;
            if (in_busy && (cyc_cnt != '1)) cyc_cnt <= cyc_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mont_mult_seq.sv
// Directed bench for mont_mult_seq with a behavioural pipelined multiplier.
module tb_mont_mult_seq;

    localparam int unsigned W   = 128;
    localparam int unsigned MW  = 129;
    localparam int unsigned LAT = 3;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [W-1:0]    a, b, n, nprime;
    logic            busy, done;
    logic [W-1:0]    res;
    logic [MW-1:0]   mul_a, mul_b;
    logic [2*MW-1:0] mul_p;
`ifdef MONT_PERF_CNT_EN
    logic [31:0]     op_cnt, cyc_cnt;
`endif

    int total = 0;
    int bad   = 0;

    mont_mult_seq #(.W(W), .MW(MW), .MUL_LAT(LAT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .n      (n),
        .nprime (nprime),
        .busy   (busy),
        .done   (done),
        .res    (res),
        .mul_a  (mul_a),
        .mul_b  (mul_b),
        .mul_p  (mul_p)
`ifdef MONT_PERF_CNT_EN
        ,
        .op_cnt (op_cnt),
        .cyc_cnt(cyc_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External multiplier: LAT register stages from operands to product.
    logic [2*MW-1:0] pipe [LAT];
    always_ff @(posedge clk) begin
        pipe[0] <= (2*MW)'(mul_a) * (2*MW)'(mul_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_p = pipe[LAT-1];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-serial Montgomery reference (radix 2), fully reduced for a,b < n.
    function automatic logic [W-1:0] mont_ref(input logic [W-1:0] av, bv, nv);
        logic [W+1:0] x;
        x = '0;
        for (int i = 0; i < W; i++) begin
            if (av[i]) x = x + {2'b00, bv};
            if (x[0])  x = x + {2'b00, nv};
            x = x >> 1;
        end
        if (x >= {2'b00, nv}) x = x - {2'b00, nv};
        return x[W-1:0];
    endfunction

    // One operation: checks latency, busy length and result.
    task automatic run_op(input logic [W-1:0] av, bv, nv, npv, exp, input string tag);
        int lat;
        int bcnt;
        lat  = -1;
        bcnt = 0;
        a = av; b = bv; n = nv; nprime = npv;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 30 && lat < 0; k++) begin
            tick();
            if (busy) bcnt++;
            if (done) lat = k;
        end
        check({tag, ".lat"},  lat,  14);
        check({tag, ".busy"}, bcnt, 13);
        check({tag, ".res"},  res,  exp);
    endtask

    logic [W-1:0] n1, np1, n2, np2, p127, p126, ra, rb;
    int           dcnt;
    int           dcyc [3];
    logic [W-1:0] dres [3];

    initial begin
        n1   = (W'(1) << 127) | W'(1);
        np1  = (W'(1) << 127) - W'(1);
        n2   = '1;
        np2  = W'(1);
        p127 = W'(1) << 127;
        p126 = W'(1) << 126;

        rst_n = 1'b0; start = 1'b0;
        a = '0; b = '0; n = '0; nprime = '0;
        repeat (3) tick();
        check("rst.busy",  busy,  0);
        check("rst.done",  done,  0);
        check("rst.res",   res,   0);
        check("rst.mul_a", mul_a, 0);
        check("rst.mul_b", mul_b, 0);
        rst_n = 1'b1;
        tick();

        // N = 2^127+1: R mod N = 2^127-1, R^-1 mod N = 2^126.
        run_op(W'(5), np1, n1, np1, W'(5), "ident");
        run_op(W'(0), W'(12345), n1, np1, W'(0), "zero");
        run_op(p127, p127, n1, np1, p126, "rinv");
`ifdef MONT_PERF_CNT_EN
        check("perf.op",  op_cnt,  3);
        check("perf.cyc", cyc_cnt, 39);
`endif
        // N = 2^128-1, N' = 1: res = a*b mod N; (N-1)^2 gives U = R, subtract taken.
        run_op(W'(3), W'(5), n2, np2, W'(15), "small");
        run_op(n2 - W'(1), n2 - W'(1), n2, np2, W'(1), "sub");
        run_op(p127, W'(2), n2, np2, W'(1), "wrap");

        for (int i = 0; i < 20; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            if (i[0]) begin
                ra = ra % n1; rb = rb % n1;
                run_op(ra, rb, n1, np1, mont_ref(ra, rb, n1), "rnd1");
            end else begin
                ra = ra % n2; rb = rb % n2;
                run_op(ra, rb, n2, np2, mont_ref(ra, rb, n2), "rnd2");
            end
        end

        // Extra start pulses sampled at cycles 4 and 14 are ignored.
        a = p127; b = W'(2); n = n2; nprime = np2;
        start = 1'b1;
        tick();
        start = 1'b0;
        dcnt = 0; dcyc[0] = -1;
        for (int k = 1; k <= 35; k++) begin
            tick();
            if (done) begin
                if (dcnt == 0) dcyc[0] = k;
                dcnt++;
            end
            start = (k == 3) || (k == 13);
        end
        check("pulse.cnt", dcnt, 1);
        check("pulse.cyc", dcyc[0], 14);
        check("pulse.res", res, 1);

        // start held for 40 cycles; inputs change while ops are running.
        a = W'(3); b = W'(5); n = n2; nprime = np2;
        start = 1'b1;
        tick();
        dcnt = 0;
        for (int j = 0; j < 3; j++) begin dcyc[j] = -1; dres[j] = '0; end
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (done) begin
                if (dcnt < 3) begin dcyc[dcnt] = k; dres[dcnt] = res; end
                dcnt++;
            end
            if (k == 2)  begin a = W'(7);  b = W'(9);  end
            if (k == 16) begin a = W'(10); b = W'(10); end
            if (k == 39) start = 1'b0;
        end
        check("hold.cnt",  dcnt,    3);
        check("hold.cyc0", dcyc[0], 14);
        check("hold.cyc1", dcyc[1], 29);
        check("hold.cyc2", dcyc[2], 44);
        check("hold.res0", dres[0], 15);
        check("hold.res1", dres[1], 63);
        check("hold.res2", dres[2], 100);

        // Reset sampled at cycle 7 aborts the op.
        a = W'(5); b = np1; n = n1; nprime = np1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        check("abort.busy",  busy,  0);
        check("abort.done",  done,  0);
        check("abort.res",   res,   0);
        check("abort.mul_a", mul_a, 0);
        check("abort.mul_b", mul_b, 0);
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) dcnt++;
        end
        check("abort.nodone", dcnt, 0);
        run_op(W'(6), W'(7), n2, np2, W'(42), "after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
